// File: rtl/pipe_pkg.sv
// Shared pipeline-register types for the pipelined RISC-V core.
// Control bits travel as one packed struct so every stage register zeroes them the same way.
package pipe_pkg;

  localparam int unsigned ALU_CTRL_W = 3;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  alu_src;
    logic                  jalr_ctrl;
    logic                  valid;
  } ctrl_e_t;

  localparam ctrl_e_t CTRL_BUBBLE = '0;

  // Strip the architecturally visible effects of a non-instruction, keep the rest.
  function automatic ctrl_e_t kill_side_effects(ctrl_e_t c);
    ctrl_e_t r;
    r           = c;
    r.reg_write = 1'b0;
    r.mem_write = 1'b0;
    r.jump      = 1'b0;
    r.branch    = 1'b0;
    r.valid     = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register with stall, flush, valid tracking
// and a saturating bubble counter.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 ClrCnt,
  input  logic                 ValidD,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic                 JALRctrlD,
  input  logic [1:0]           ResultSrcD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  input  logic [REG_IDX_W-1:0] RdD,
  output logic                 ValidE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic                 JALRctrlE,
  output logic [1:0]           ResultSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [REG_IDX_W-1:0] Rs1E,
  output logic [REG_IDX_W-1:0] Rs2E,
  output logic [REG_IDX_W-1:0] RdE,
  output logic [CNT_W-1:0]     BubbleCnt
);

  ctrl_e_t ctrl_d;
  ctrl_e_t ctrl_q;
  logic    bubble;

  always_comb begin
    ctrl_d             = CTRL_BUBBLE;
    ctrl_d.reg_write   = RegWriteD;
    ctrl_d.result_src  = ResultSrcD;
    ctrl_d.mem_write   = MemWriteD;
    ctrl_d.jump        = JumpD;
    ctrl_d.branch      = BranchD;
    ctrl_d.alu_control = ALU_CTRL_W'(ALUControlD);
    ctrl_d.alu_src     = ALUSrcD;
    ctrl_d.jalr_ctrl   = JALRctrlD;
    ctrl_d.valid       = ValidD;
    if (!ValidD) begin
      ctrl_d = kill_side_effects(ctrl_d);
    end
  end

  // A stall with ValidD low is not a bubble: nothing new is loaded.
  assign bubble = FlushE | (~StallE & ~ValidD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= CTRL_BUBBLE;
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      ImmExtE  <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
    end else if (FlushE) begin
      ctrl_q   <= CTRL_BUBBLE;
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      ImmExtE  <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
    end else if (!StallE) begin
      ctrl_q   <= ctrl_d;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      PCE      <= PCD;
      ImmExtE  <= ImmExtD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
    end
  end

  assign ValidE      = ctrl_q.valid;
  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign JALRctrlE   = ctrl_q.jalr_ctrl;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ALUCTRL_W'(ctrl_q.alu_control);

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (bubble),
    .clr  (ClrCnt),
    .count(BubbleCnt)
  );

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: stimulus queues hand-built expected E-side
// snapshots, a monitor pops and compares one after every rising edge.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        v, rw, mw, j, b, alusrc, jalr;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, pc, imm, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } obs_t;

  typedef struct packed {
    logic [15:0] id;
    obs_t        exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic StallE = 1'b0, FlushE = 1'b0, ClrCnt = 1'b0;
  logic ValidD = 1'b0, RegWriteD = 1'b0, MemWriteD = 1'b0, JumpD = 1'b0;
  logic BranchD = 1'b0, ALUSrcD = 1'b0, JALRctrlD = 1'b0;
  logic [1:0]  ResultSrcD = '0;
  logic [2:0]  ALUControlD = '0;
  logic [31:0] RD1D = '0, RD2D = '0, PCD = '0, ImmExtD = '0, PCPlus4D = '0;
  logic [4:0]  Rs1D = '0, Rs2D = '0, RdD = '0;

  logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRctrlE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] BubbleCnt;

  logic q_v, q_rw, q_mw, q_j, q_b, q_alusrc, q_jalr;
  logic [1:0]  q_rs;
  logic [2:0]  q_alu;
  logic [31:0] q_rd1, q_rd2, q_pc, q_imm, q_pc4;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic [3:0]  q_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ClrCnt(ClrCnt),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .JALRctrlE(JALRctrlE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .BubbleCnt(BubbleCnt)
  );

  id_ex_pipe_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ClrCnt(ClrCnt),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(q_v), .RegWriteE(q_rw), .MemWriteE(q_mw), .JumpE(q_j),
    .BranchE(q_b), .ALUSrcE(q_alusrc), .JALRctrlE(q_jalr), .ResultSrcE(q_rs),
    .ALUControlE(q_alu), .RD1E(q_rd1), .RD2E(q_rd2), .PCE(q_pc), .ImmExtE(q_imm),
    .PCPlus4E(q_pc4), .Rs1E(q_rs1), .Rs2E(q_rs2), .RdE(q_rd), .BubbleCnt(q_cnt)
  );

  function automatic obs_t sample_main();
    return '{ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRctrlE,
             ResultSrcE, ALUControlE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
             Rs1E, Rs2E, RdE, BubbleCnt, q_cnt};
  endfunction

  function automatic obs_t sample_small();
    return '{q_v, q_rw, q_mw, q_j, q_b, q_alusrc, q_jalr, q_rs, q_alu,
             q_rd1, q_rd2, q_pc, q_imm, q_pc4, q_rs1, q_rs2, q_rd, BubbleCnt, q_cnt};
  endfunction

  task automatic compare(input int id, input obs_t act, input obs_t exp, input string who);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL step%0d %s: got %h expected %h", id, who, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      compare(int'(e.id), sample_main(), e.exp, "dut");
      compare(int'(e.id), sample_small(), e.exp, "dut4");
    end
  end

  // Inputs: valid rw mw j b alusrc jalr rs alu rd1 rd2 pc imm pc4 rs1 rs2 rd (cnt fields ignored)
  task automatic set_in(input obs_t d, input logic st, input logic fl, input logic cl);
    {ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD} =
      {d.v, d.rw, d.mw, d.j, d.b, d.alusrc, d.jalr};
    ResultSrcD = d.rs; ALUControlD = d.alu;
    RD1D = d.rd1; RD2D = d.rd2; PCD = d.pc; ImmExtD = d.imm; PCPlus4D = d.pc4;
    Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd;
    StallE = st; FlushE = fl; ClrCnt = cl;
  endtask

  task automatic step(input int id, input obs_t d, input logic st, input logic fl,
                      input logic cl, input obs_t exp);
    set_in(d, st, fl, cl);
    sb.push_back('{16'(id), exp});
    @(negedge clk);
  endtask

  obs_t a, b, c, c_exp, dd, f, zero, blank;
  logic [15:0] e16;
  logic [3:0]  e4;

  initial begin
    zero = '0;
    a  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b010,
           32'h1111_1111, 32'h2222_2222, 32'h100, 32'h4, 32'h104, 5'd1, 5'd2, 5'd5, 16'd0, 4'd0};
    c  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 3'b101,
           32'h33, 32'h44, 32'h200, 32'h10, 32'h204, 5'd3, 5'd4, 5'd7, 16'd0, 4'd0};
    dd = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 3'b111,
           32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h300, 32'hFFFF_FFF0, 32'h304, 5'd31, 5'd30, 5'd29, 16'd2, 4'd2};
    f  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b001,
           32'hDEAD_BEEF, 32'h0, 32'h400, 32'h0, 32'h404, 5'd8, 5'd9, 5'd10, 16'd0, 4'd0};

    #2;
    compare(0, sample_main(), zero, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(1, a, 1'b0, 1'b0, 1'b0, a);

    // Stall three cycles with changing inputs: outputs frozen at A, no bubbles.
    for (int i = 0; i < 3; i++) begin
      b = a;
      b.rd1 = 32'hBAD0_0000 + 32'(i);
      b.pc  = 32'h900 + 32'(4 * i);
      b.rd  = 5'(20 + i);
      b.mw  = 1'b1;
      step(2 + i, b, 1'b1, 1'b0, 1'b0, a);
    end

    b = a; b.mw = 1'b1;
    blank = zero; blank.cnt = 16'd1; blank.cnt4 = 4'd1;
    step(5, b, 1'b1, 1'b1, 1'b0, blank);

    // ValidD=0 capture: side effects cleared, data and datapath selects captured.
    c_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 3'b101,
              32'h33, 32'h44, 32'h200, 32'h10, 32'h204, 5'd3, 5'd4, 5'd7, 16'd2, 4'd2};
    step(6, c, 1'b0, 1'b0, 1'b0, c_exp);

    step(7, dd, 1'b0, 1'b0, 1'b0, dd);

    e16 = 16'd2; e4 = 4'd2;
    for (int i = 0; i < 20; i++) begin
      e16 = e16 + 16'd1;
      if (e4 != 4'd15) e4 = e4 + 4'd1;
      blank = zero; blank.cnt = e16; blank.cnt4 = e4;
      step(10 + i, dd, 1'b0, 1'b1, 1'b0, blank);
    end

    step(30, dd, 1'b0, 1'b1, 1'b1, zero);

    blank = zero; blank.cnt = 16'd1; blank.cnt4 = 4'd1;
    step(31, dd, 1'b0, 1'b1, 1'b0, blank);
    step(32, c, 1'b1, 1'b0, 1'b0, blank);

    // Asynchronous reset between edges while new D-side data is presented.
    set_in(f, 1'b0, 1'b0, 1'b0);
    sb.push_back('{16'd33, f});
    #1 rst_n = 1'b0;
    #1 compare(34, sample_main(), zero, "async_reset");
    compare(35, sample_small(), zero, "async_reset4");
    #1 rst_n = 1'b1;
    @(negedge clk);

    set_in(zero, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
